mul_arb: RTL

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mul_arb.sv
// mul_arb: two-requester round-robin front end for one shared pipelined
// multiplier. Operand pairs are issued one cycle after the handshake. A
// MUL_LAT-deep tag pipeline predicts when each result returns and which
// requester owns it. Results are routed combinationally to that requester.
// A result strobe that disagrees with the prediction sets a sticky err flag.
// The optional macro MUL_ARB_STAT_EN adds saturating 16-bit grant counters
// gnt0_cnt/gnt1_cnt.
module mul_arb #(
  parameter int SIGN_W  = 1,
  parameter int EXPO_W  = 8,
  parameter int MANT_W  = 23,
  parameter int MUL_LAT = 3,
  localparam int W      = SIGN_W + EXPO_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         mul_valid,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic         mul_res_valid,
  input  logic [W-1:0] mul_res,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_res,
  output logic         err
`ifdef MUL_ARB_STAT_EN
  ,
  output logic [15:0]  gnt0_cnt,
  output logic [15:0]  gnt1_cnt
`endif
);

  // ptr_q names the requester favoured when both are valid (0 after reset).
  logic         ptr_q, ptr_d;
  logic         gnt0, gnt1, hs;

  logic         mul_valid_q, mul_valid_d;
  logic         mul_id_q, mul_id_d;
  logic [W-1:0] mul_a_q, mul_a_d;
  logic [W-1:0] mul_b_q, mul_b_d;

  // Tag pipeline. Stage 0 follows the issue register, so stage MUL_LAT-1
  // lines up with the multiplier output MUL_LAT cycles after issue.
  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [MUL_LAT-1:0] tag_id_q, tag_id_d;

  logic         exp_v, exp_id, mismatch;
  logic         err_q, err_d;

  // Grant: the favoured requester wins a tie, and a lone requester always wins.
  // Nothing is granted while rst is high.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    hs    = gnt0 | gnt1;
    ptr_d = hs ? gnt0 : ptr_q;  // after granting 0, favour 1 and vice versa
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Issue stage next state: capture the granted pair, or hold the operands when idle.
  always_comb begin
    mul_valid_d = hs;
    mul_id_d    = hs ? gnt1 : mul_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    if (gnt0) begin
      mul_a_d = req0_a;
      mul_b_d = req0_b;
    end else if (gnt1) begin
      mul_a_d = req1_a;
      mul_b_d = req1_b;
    end
  end

  // Tag pipeline next state, one stage per generate iteration.
  generate
    for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        assign tag_v_d[gi]  = mul_valid_q;
        assign tag_id_d[gi] = mul_id_q;
      end else begin : g_rest
        assign tag_v_d[gi]  = tag_v_q[gi-1];
        assign tag_id_d[gi] = tag_id_q[gi-1];
      end
    end
  endgenerate

  assign exp_v  = tag_v_q[MUL_LAT-1];
  assign exp_id = tag_id_q[MUL_LAT-1];

  // Result routing and error detection. A result is only forwarded when it matches the prediction.
  always_comb begin
    mismatch   = !rst && (mul_res_valid != exp_v);
    rsp0_valid = !rst && exp_v && mul_res_valid && !exp_id;
    rsp1_valid = !rst && exp_v && mul_res_valid &&  exp_id;
    err_d      = err_q | mismatch;
  end

  assign rsp_res   = mul_res;
  assign err       = err_q | mismatch;  // raised in the same cycle as the mismatch
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  // State registers for the arbiter, issue stage, tag pipeline and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_id_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_id_q    <= mul_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      err_q       <= err_d;
    end
  end

`ifdef MUL_ARB_STAT_EN
  logic [15:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [15:0] gnt1_cnt_q, gnt1_cnt_d;

  // Saturating per-requester handshake counters.
  always_comb begin
    gnt0_cnt_d = gnt0_cnt_q;
    gnt1_cnt_d = gnt1_cnt_q;
    if (gnt0 && gnt0_cnt_q != 16'hFFFF) gnt0_cnt_d = gnt0_cnt_q + 16'd1;
    if (gnt1 && gnt1_cnt_q != 16'hFFFF) gnt1_cnt_d = gnt1_cnt_q + 16'd1;
  end

  // Counter registers, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      gnt0_cnt_q <= gnt0_cnt_d;
      gnt1_cnt_q <= gnt1_cnt_d;
    end
  end

  assign gnt0_cnt = gnt0_cnt_q;
  assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule
